// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data/index widths, the hardwired zero register
// index, and the write-back bus struct used by the MEM/WB register, the
// write-back stage and the forwarding unit.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              en;
    } wb_bus_t;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> write-back bus plus the ID-stage read ports and the forwarding
// taps.
//   master : pipeline side, drives MEM/WB fields and read indices
//   slave  : wb_regfile, returns read data and forwarding info
interface wb_regfile_if;
    import pipeline_pkg::*;

    logic [DATA_W-1:0] memrdatain;
    logic [DATA_W-1:0] ALUresultin;
    logic [ADDR_W-1:0] rt_rddin;
    logic              MemtoRegin;
    logic              Regwritein;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_en;

    modport master (
        output memrdatain, ALUresultin, rt_rddin, MemtoRegin, Regwritein,
               rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_rd, wb_en
    );

    modport slave (
        input  memrdatain, ALUresultin, rt_rddin, MemtoRegin, Regwritein,
               rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_rd, wb_en
    );

endinterface

// File: rtl/wb_regfile_rf2r1w.sv
// regfile_2r1w: bare 2-read / 1-write register array.
//   clk, rst      : clock, synchronous active-high clear of every entry
//   we_i/waddr_i/wdata_i : write port (index 0 writes are dropped)
//   raddr_a_i/raddr_b_i  : combinational read indices
//   rdata_a_o/rdata_b_o  : read data, index 0 always reads 0
module regfile_2r1w
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Entry 0 is never written, but force the read anyway so register 0 is
    // zero even before the first reset edge.
    assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage + architectural register file.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : MEM/WB inputs, ID read ports, forwarding outputs (slave side)
//   wr_count  : committed register writes since reset, wraps at 2**CNT_W
module wb_regfile
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_regfile_if.slave      bus,
    output logic [CNT_W-1:0] wr_count
);

    wb_bus_t           wb;
    logic [DATA_W-1:0] arr_a, arr_b;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    // Write-back select and effective enable. Masking with rst keeps the
    // forwarding unit and the bypass from seeing a write that reset discards.
    always_comb begin
        wb.data = bus.MemtoRegin ? bus.memrdatain : bus.ALUresultin;
        wb.en   = bus.Regwritein && (bus.rt_rddin != REG_ZERO) && !rst;
        wb.rd   = wb.en ? bus.rt_rddin : REG_ZERO;
    end

    regfile_2r1w u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb.en),
        .waddr_i   (wb.rd),
        .wdata_i   (wb.data),
        .raddr_a_i (bus.rs_addr),
        .raddr_b_i (bus.rt_addr),
        .rdata_a_o (arr_a),
        .rdata_b_o (arr_b)
    );

    // Write-through bypass: wb.rd is never 0 while wb.en is set, so a read of
    // index 0 can never match and still returns 0 from the array.
    always_comb begin
        bus.rs_data = (wb.en && (bus.rs_addr == wb.rd)) ? wb.data : arr_a;
        bus.rt_data = (wb.en && (bus.rt_addr == wb.rd)) ? wb.data : arr_b;
    end

    assign bus.wb_data = wb.data;
    assign bus.wb_rd   = wb.rd;
    assign bus.wb_en   = wb.en;

    assign wr_count_d = wb.en ? wr_count_q + 1'b1 : wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) wr_count_q <= '0;
        else     wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] wr_count;

    wb_regfile_if bus ();

    wb_regfile #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rs_data;
        logic [31:0]   rt_data;
        logic [31:0]   wb_data;
        logic [4:0]    wb_rd;
        logic          wb_en;
        logic [CW-1:0] wr_count;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain array of architectural values and a counter.
    logic [31:0] ref_mem [32];
    int          ref_cnt;

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the
    // falling edge against whatever the stimulus queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rs_data",  e.tag, bus.rs_data, e.rs_data);
                chk("rt_data",  e.tag, bus.rt_data, e.rt_data);
                chk("wb_data",  e.tag, bus.wb_data, e.wb_data);
                chk("wb_rd",    e.tag, 32'(bus.wb_rd), 32'(e.wb_rd));
                chk("wb_en",    e.tag, 32'(bus.wb_en), 32'(e.wb_en));
                chk("wr_count", e.tag, 32'(wr_count), 32'(e.wr_count));
            end
        end
    end

    // Drive one cycle, queue its expected outputs, then advance the model
    // past the upcoming rising edge.
    task automatic step(input string tag, input bit r, input bit mtr, input bit rw,
                        input logic [4:0] rd, input logic [31:0] md, input logic [31:0] alu,
                        input logic [4:0] rs, input logic [4:0] rt);
        exp_t        e;
        logic [31:0] wbd;
        bit          en;
        @(posedge clk);
        #2;
        rst             = r;
        bus.MemtoRegin  = mtr;
        bus.Regwritein  = rw;
        bus.rt_rddin    = rd;
        bus.memrdatain  = md;
        bus.ALUresultin = alu;
        bus.rs_addr     = rs;
        bus.rt_addr     = rt;
        wbd = mtr ? md : alu;
        en  = rw && (rd != 0) && !r;
        e.tag      = tag;
        e.wb_data  = wbd;
        e.wb_en    = en;
        e.wb_rd    = en ? rd : 5'd0;
        e.rs_data  = (rs == 0) ? 32'd0 : (en && rs == rd) ? wbd : ref_mem[rs];
        e.rt_data  = (rt == 0) ? 32'd0 : (en && rt == rd) ? wbd : ref_mem[rt];
        e.wr_count = CW'(ref_cnt);
        exp_q.push_back(e);
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = 32'd0;
            ref_cnt = 0;
        end else if (en) begin
            ref_mem[rd] = wbd;
            ref_cnt = (ref_cnt + 1) % (1 << CW);
        end
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        ref_cnt = 0;
        // Reset asserted from time 0 with a write pending: it must be lost.
        rst = 1'b1;
        bus.MemtoRegin = 1'b0; bus.Regwritein = 1'b1; bus.rt_rddin = 5'd10;
        bus.memrdatain = 32'd0; bus.ALUresultin = 32'd77;
        bus.rs_addr = 5'd10; bus.rt_addr = 5'd0;

        step("rst2",  1, 0, 1, 5'd10, 32'd0, 32'd77, 5'd10, 5'd10);
        for (int i = 0; i < 32; i++)
            step("rd0", 0, 0, 0, 5'd10, 32'd0, 32'd0, 5'(i), 5'(31 - i));

        step("aluwb",  0, 0, 1, 5'd10, 32'd1234, 32'd5678, 5'd1, 5'd2);
        step("aluchk", 0, 0, 0, 5'd0,  32'd0,    32'd0,    5'd10, 5'd0);
        step("membyp", 0, 1, 1, 5'd5,  32'd8765, 32'd1,    5'd5, 5'd5);
        step("memchk", 0, 0, 0, 5'd0,  32'd0,    32'd0,    5'd5, 5'd10);
        step("zero",   0, 0, 1, 5'd0,  32'd3,    32'hFFFF_FFFF, 5'd0, 5'd0);
        step("zchk",   0, 0, 0, 5'd0,  32'd0,    32'd0,    5'd0, 5'd5);
        step("nowr",   0, 0, 0, 5'd5,  32'd0,    32'd42,   5'd5, 5'd5);
        step("nowchk", 0, 0, 0, 5'd0,  32'd0,    32'd0,    5'd5, 5'd0);
        step("rstwr",  1, 0, 1, 5'd3,  32'd0,    32'd99,   5'd3, 5'd3);
        step("rstchk", 0, 0, 0, 5'd0,  32'd0,    32'd0,    5'd3, 5'd5);

        // 17 committed writes on a 4-bit counter leave it at 1.
        for (int i = 0; i < 17; i++)
            step("wrap", 0, i[0], 1, 5'(1 + (i % 31)), 32'(i * 3), 32'(i * 7), 5'(i), 5'(i + 1));
        step("wrapchk", 0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd17);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                 rd, $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
